// File: rtl/fht_ram_bank_array.sv
// Multi-bank FHT data store: BANKS banks with 1R/1W each, optional ping-pong paging
// (FHT_RAM_PINGPONG_EN) and a hardware zero-fill sequencer.
module fht_ram_bank_array #(
  parameter int D_BIT = 17,
  parameter int A_BIT = 8,
  parameter int DEPTH = 256,
  parameter int BANKS = 4
) (
  input  logic                   iCLK,
  input  logic                   iRESET,
  input  logic                   iCLEAR,
  input  logic                   iSWAP,
  input  logic [BANKS*D_BIT-1:0] iDATA,
  input  logic [BANKS*A_BIT-1:0] iADDR_RD,
  input  logic [BANKS*A_BIT-1:0] iADDR_WR,
  input  logic [BANKS-1:0]       iWE,
  output logic [BANKS*D_BIT-1:0] oDATA,
  output logic                   oPAGE,
  output logic                   oBUSY
);

`ifdef FHT_RAM_PINGPONG_EN
  localparam int PHYS = 2 * DEPTH;
`else
  localparam int PHYS = DEPTH;
`endif
  localparam int PA = (PHYS > 1) ? $clog2(PHYS) : 1;
  localparam int unsigned LAST = PHYS - 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                 state, stateNext;
  logic [PA-1:0]          cnt, cntNext;
  logic                   page, pageNext, wrPage, busy;
  logic [D_BIT-1:0]       mem [BANKS][PHYS];
  logic [BANKS*D_BIT-1:0] rdReg;
  logic [BANKS-1:0]       rdOk, wrOk;

`ifdef FHT_RAM_PINGPONG_EN
  assign wrPage = ~page;
`else
  logic unusedSwap;
  assign unusedSwap = iSWAP;
  assign wrPage     = page;
`endif

  assign busy  = (state == CLEAR);
  assign oBUSY = busy;
  assign oPAGE = page;
  assign oDATA = busy ? '0 : rdReg;

  for (genvar k = 0; k < BANKS; k++) begin : gRange
    if (DEPTH < (1 << A_BIT)) begin : gCmp
      assign rdOk[k] = iADDR_RD[k*A_BIT +: A_BIT] < A_BIT'(DEPTH);
      assign wrOk[k] = iADDR_WR[k*A_BIT +: A_BIT] < A_BIT'(DEPTH);
    end else begin : gFull
      assign rdOk[k] = 1'b1;
      assign wrOk[k] = 1'b1;
    end
  end

  // Page p occupies physical words p*DEPTH .. p*DEPTH+DEPTH-1, i.e. {page, addr}
  // when DEPTH is a power of two, and stays dense otherwise.
  function automatic logic [PA-1:0] physAddr(input logic pg, input logic [A_BIT-1:0] a);
    physAddr = PA'(a);
    if (pg) physAddr = physAddr + PA'(DEPTH);
  endfunction

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    pageNext  = page;
    case (state)
      IDLE: begin
        if (iCLEAR) stateNext = CLEAR;
`ifdef FHT_RAM_PINGPONG_EN
        if (iSWAP) pageNext = ~page;
`endif
      end
      CLEAR: begin
        if (cnt == PA'(LAST)) begin
          stateNext = IDLE;
          cntNext   = '0;
        end else begin
          cntNext = cnt + PA'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state <= IDLE;
      cnt   <= '0;
      page  <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      page  <= pageNext;
    end
  end

  // Storage has no reset; reset only suppresses writes so contents survive it.
  always_ff @(posedge iCLK) begin
    for (int unsigned k = 0; k < BANKS; k++) begin
      if (!iRESET) begin
        if (busy)
          mem[k][cnt] <= '0;
        else if (iWE[k] && wrOk[k])
          mem[k][physAddr(wrPage, iADDR_WR[k*A_BIT +: A_BIT])] <= iDATA[k*D_BIT +: D_BIT];
      end
    end
  end

  always_ff @(posedge iCLK) begin
    for (int unsigned k = 0; k < BANKS; k++) begin
      if (iRESET || busy || !rdOk[k])
        rdReg[k*D_BIT +: D_BIT] <= '0;
      else
        rdReg[k*D_BIT +: D_BIT] <= mem[k][physAddr(page, iADDR_RD[k*A_BIT +: A_BIT])];
    end
  end

endmodule
